// File: rtl/tick_generator_if.sv
// Configuration port of the tick generator: a valid/ready write channel
// carrying channel index, increment, enable and clear, plus an error pulse.
interface tick_generator_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [3:0]           cfg_chan;
    logic [ACC_WIDTH-1:0] cfg_inc;
    logic                 cfg_enable;
    logic                 cfg_clear;
    logic                 cfg_err;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_inc,
        output cfg_enable,
        output cfg_clear,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_inc,
        input  cfg_enable,
        input  cfg_clear,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/tick_generator.sv
// Multi-channel fractional-N tick generator: one phase accumulator per channel,
// carry out gives a tick pulse and toggles a square-wave output.
module tick_generator #(
    parameter int                        CHANNELS  = 3,
    parameter int                        ACC_WIDTH = 32,
    parameter longint unsigned           CLK_FREQ  = 64'd50000000,
    parameter logic [CHANNELS*32-1:0]    FREQ_INIT = {32'd25000000, 32'd32768, 32'd115200}
) (
    input  logic                clock,
    input  logic                reset,
    tick_generator_if.slave     cfg,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out
);

    // Rounded increment for a requested tick frequency; the 64-bit product wraps
    // for very wide accumulators, which is the accepted elaboration-time behaviour.
    function automatic logic [ACC_WIDTH-1:0] inc_init(input int c);
        logic [63:0] num;
        num = ({32'd0, FREQ_INIT[c*32 +: 32]} << ACC_WIDTH) + (CLK_FREQ / 64'd2);
        num = num / CLK_FREQ;
        return num[ACC_WIDTH-1:0];
    endfunction

    logic [ACC_WIDTH-1:0] acc_r [CHANNELS];
    logic [ACC_WIDTH-1:0] inc_r [CHANNELS];
    logic [CHANNELS-1:0]  en_r;
    logic                 ready_r;
    logic                 err_r;

    logic                 accept_s;
    logic                 chan_ok_s;
    logic [CHANNELS-1:0]  hit_s;
    logic [ACC_WIDTH:0]   sum_s [CHANNELS];

    assign cfg.cfg_ready = ready_r;
    assign cfg.cfg_err   = err_r;

    // Write decode and per-channel accumulator sums with carry bit
    always_comb begin
        hit_s     = {CHANNELS{1'b0}};
        accept_s  = cfg.cfg_valid && ready_r;
        chan_ok_s = ({28'd0, cfg.cfg_chan} < 32'(CHANNELS));
        for (int c = 0; c < CHANNELS; c++) begin
            hit_s[c] = accept_s && ({28'd0, cfg.cfg_chan} == 32'(c));
            sum_s[c] = {1'b0, acc_r[c]} + {1'b0, inc_r[c]};
        end
    end

    // Handshake: ready drops for one cycle after each accepted write
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            ready_r <= ~accept_s;
            err_r   <= accept_s && !chan_ok_s;
        end
    end

    // Channel state: a clear overrides the carry of the add it coincides with,
    // while inc/en only take effect for the add after the accepting edge
    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (reset) begin
                acc_r[c]   <= {ACC_WIDTH{1'b0}};
                inc_r[c]   <= inc_init(c);
                en_r[c]    <= 1'b1;
                tick[c]    <= 1'b0;
                clk_out[c] <= 1'b0;
            end else begin
                if (hit_s[c] && cfg.cfg_clear) begin
                    acc_r[c]   <= {ACC_WIDTH{1'b0}};
                    tick[c]    <= 1'b0;
                    clk_out[c] <= 1'b0;
                end else if (en_r[c]) begin
                    acc_r[c] <= sum_s[c][ACC_WIDTH-1:0];
                    tick[c]  <= sum_s[c][ACC_WIDTH];
                    if (sum_s[c][ACC_WIDTH]) begin
                        clk_out[c] <= ~clk_out[c];
                    end else begin
                        clk_out[c] <= clk_out[c];
                    end
                end else begin
                    tick[c] <= 1'b0;
                end
                if (hit_s[c]) begin
                    inc_r[c] <= cfg.cfg_inc;
                    en_r[c]  <= cfg.cfg_enable;
                end else begin
                    inc_r[c] <= inc_r[c];
                    en_r[c]  <= en_r[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_generator.sv
// Randomized bench for tick_generator: an arithmetic phase model predicts every
// output each cycle, plus literal expectations for the characteristic patterns.
module tb_tick_generator;

    localparam int              NCH  = 3;
    localparam longint unsigned MODV = 64'h1_0000_0000;
    localparam longint unsigned FCLK = 64'd50000000;

    logic           clock;
    logic           reset;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;

    int checks = 0;
    int errors = 0;

    tick_generator_if #(.ACC_WIDTH(32)) cfg ();

    tick_generator dut (
        .clock   (clock),
        .reset   (reset),
        .cfg     (cfg),
        .tick    (tick),
        .clk_out (clk_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    function automatic longint unsigned init_inc(input int c);
        longint unsigned f;
        f = (c == 0) ? 64'd115200 : (c == 1) ? 64'd32768 : 64'd25000000;
        return (f * MODV + FCLK / 64'd2) / FCLK;
    endfunction

    // Model: accumulator value = (base + n*inc) mod 2^32, where n counts enabled
    // adds since the last reprogramming; a tick is a change of floor((base+n*inc)/2^32).
    longint unsigned m_base [NCH];
    longint unsigned m_n    [NCH];
    longint unsigned m_prev [NCH];
    longint unsigned m_inc  [NCH];
    bit              m_en   [NCH];
    bit              m_tick [NCH];
    bit              m_clk  [NCH];
    bit              m_ready;
    bit              m_err;

    initial begin
        bit accept, hit;
        int ch;
        longint unsigned cur;
        forever begin
            @(posedge clock);
            if (reset) begin
                for (int c = 0; c < NCH; c++) begin
                    m_base[c] = 0; m_n[c] = 0; m_prev[c] = 0;
                    m_inc[c] = init_inc(c); m_en[c] = 1'b1;
                    m_tick[c] = 1'b0; m_clk[c] = 1'b0;
                end
                m_ready = 1'b1;
                m_err   = 1'b0;
            end else begin
                accept = cfg.cfg_valid && m_ready;
                ch     = int'(cfg.cfg_chan);
                hit    = accept && (ch < NCH);
                for (int c = 0; c < NCH; c++) begin
                    if (hit && ch == c && cfg.cfg_clear) begin
                        m_base[c] = 0; m_n[c] = 0; m_prev[c] = 0;
                        m_tick[c] = 1'b0; m_clk[c] = 1'b0;
                    end else if (m_en[c]) begin
                        m_n[c]++;
                        cur       = (m_base[c] + m_n[c] * m_inc[c]) / MODV;
                        m_tick[c] = (cur != m_prev[c]);
                        m_prev[c] = cur;
                        m_clk[c]  = m_clk[c] ^ m_tick[c];
                    end else begin
                        m_tick[c] = 1'b0;
                    end
                    if (hit && ch == c) begin
                        m_base[c] = (m_base[c] + m_n[c] * m_inc[c]) % MODV;
                        m_n[c] = 0; m_prev[c] = 0;
                        m_inc[c] = longint'(cfg.cfg_inc);
                        m_en[c]  = cfg.cfg_enable;
                    end
                end
                m_ready = !accept;
                m_err   = accept && !hit;
            end
            @(negedge clock);
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("model tick[%0d] t=%0t", c, $time), tick[c], m_tick[c]);
                chk($sformatf("model clk_out[%0d] t=%0t", c, $time), clk_out[c], m_clk[c]);
            end
            chk($sformatf("model cfg_ready t=%0t", $time), cfg.cfg_ready, m_ready);
            chk($sformatf("model cfg_err t=%0t", $time), cfg.cfg_err, m_err);
        end
    end

    task automatic cfg_write(input int chan, input logic [31:0] inc, input bit en, input bit clr);
        int guard;
        @(negedge clock);
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_chan   = chan[3:0];
        cfg.cfg_inc    = inc;
        cfg.cfg_enable = en;
        cfg.cfg_clear  = clr;
        guard = 0;
        while (!cfg.cfg_ready && guard < 4) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (guard >= 4) begin
            errors++;
            $display("FAIL cfg_ready timeout: got 0 expected 1 within 4 cycles");
        end
        @(negedge clock);
        cfg.cfg_valid = 1'b0;
    endtask

    initial begin
        int cnt0, cnt1, cnt2;
        logic [7:0] tpat, cpat;
        logic [31:0] rinc;
        logic saved_clk;
        int rch;

        reset = 1'b1;
        cfg.cfg_valid = 1'b0; cfg.cfg_chan = 4'd0; cfg.cfg_inc = 32'd0;
        cfg.cfg_enable = 1'b0; cfg.cfg_clear = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset tick", tick, 3'b000);
        chk("reset clk_out", clk_out, 3'b000);
        chk("reset cfg_ready", cfg.cfg_ready, 1'b1);
        chk("reset cfg_err", cfg.cfg_err, 1'b0);

        // Default rates from reset release over a 50000-cycle window
        reset = 1'b0;
        cnt0 = 0; cnt1 = 0; tpat = 8'd0; cpat = 8'd0;
        for (int k = 0; k < 50000; k++) begin
            @(negedge clock);
            cnt0 += int'(tick[0]);
            cnt1 += int'(tick[1]);
            if (k < 8) begin
                tpat[k] = tick[2];
                cpat[k] = clk_out[2];
            end
        end
        chk("ch2 tick pattern after reset", tpat, 8'b1010_1010);
        chk("ch2 clk_out pattern after reset", cpat, 8'b0110_0110);
        chk_range("ch1 ticks in 50000 cycles", cnt1, 32, 33);
        chk_range("ch0 ticks in 50000 cycles", cnt0, 114, 116);

        // Reprogram ch1 to quarter rate with clear
        cfg_write(1, 32'h4000_0000, 1'b1, 1'b1);
        chk("ch1 tick after clear", tick[1], 1'b0);
        chk("ch1 clk_out after clear", clk_out[1], 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            tpat[k] = tick[1];
        end
        chk("ch1 quarter-rate pattern", tpat, 8'b1000_1000);

        // Out-of-range channel
        cfg_write(7, 32'hFFFF_FFFF, 1'b0, 1'b1);
        chk("cfg_err pulse", cfg.cfg_err, 1'b1);
        chk("cfg_ready low after write", cfg.cfg_ready, 1'b0);
        @(negedge clock);
        chk("cfg_err single cycle", cfg.cfg_err, 1'b0);
        chk("cfg_ready restored", cfg.cfg_ready, 1'b1);

        // Disable ch2, then re-enable without clear
        cfg_write(2, 32'h8000_0000, 1'b0, 1'b0);
        saved_clk = clk_out[2];
        cnt2 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            cnt2 += int'(tick[2]);
        end
        chk("ch2 ticks while disabled", cnt2, 0);
        chk("ch2 clk_out frozen", clk_out[2], saved_clk);
        cfg_write(2, 32'h8000_0000, 1'b1, 1'b0);
        repeat (6) @(negedge clock);

        // Clear coinciding with a ch2 carry
        cfg_write(2, 32'h8000_0000, 1'b1, 1'b1);
        cfg_write(2, 32'h8000_0000, 1'b1, 1'b1);
        chk("clear wins over carry tick", tick[2], 1'b0);
        chk("clear wins over carry clk_out", clk_out[2], 1'b0);

        // Reset during a burst of ch0 ticks
        cfg_write(0, 32'hF000_0000, 1'b1, 1'b0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("reset mid-burst tick", tick, 3'b000);
        chk("reset mid-burst clk_out", clk_out, 3'b000);
        reset = 1'b0;
        cnt0 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            cnt0 += int'(tick[0]);
            if (k < 4) tpat[k] = tick[2];
        end
        chk("ch0 INC_INIT restored", cnt0, 0);
        chk("ch2 pattern after mid reset", tpat[3:0], 4'b1010);

        // Randomized writes, gaps and occasional resets
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rinc = 32'd0;
                1: rinc = $urandom_range(1, 32'h0100_0000);
                2: rinc = 32'h8000_0000 | $urandom;
                default: rinc = $urandom;
            endcase
            rch = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 15) : $urandom_range(0, NCH - 1);
            cfg_write(rch, rinc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 6)) @(negedge clock);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
        end
        repeat (5) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
